// File: rtl/reg_write_arbiter_if.sv
// Request/issue bundle between the control unit and the register-write arbiter.
interface reg_write_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic              mem_dst;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              link_valid;
  logic [DATA_W-1:0] link_data;
  logic              link_ready;
  logic              sp_valid;
  logic [DATA_W-1:0] sp_data;
  logic              sp_ready;
  logic              hold;
  logic [2:0]        BancoWriteReg;
  logic              RegWrite;
  logic [DATA_W-1:0] WriteData;
  logic              busy;

  modport master (
    output alu_valid, alu_dst, alu_data,
    output mem_valid, mem_dst, mem_data,
    output link_valid, link_data,
    output sp_valid, sp_data,
    output hold,
    input  alu_ready, mem_ready, link_ready, sp_ready,
    input  BancoWriteReg, RegWrite, WriteData, busy
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  mem_valid, mem_dst, mem_data,
    input  link_valid, link_data,
    input  sp_valid, sp_data,
    input  hold,
    output alu_ready, mem_ready, link_ready, sp_ready,
    output BancoWriteReg, RegWrite, WriteData, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-bank write port.
// Requesters: 0 = alu, 1 = mem, 2 = link, 3 = sp; each has a one-entry buffer.
module reg_write_arbiter #(
  parameter int         DATA_W    = 32,
  parameter logic [2:0] SP_CODE   = 3'd3,
  parameter logic [2:0] LINK_CODE = 3'd4
) (
  input logic            clk,
  input logic            reset,
  reg_write_arbiter_if.slave bus
);

  logic [3:0]        pend;
  logic [3:0]        valid;
  logic [3:0]        accept;
  logic [DATA_W-1:0] data_q  [4];
  logic [2:0]        code_q  [4];
  logic [DATA_W-1:0] in_data [4];
  logic [2:0]        in_code [4];
  logic [1:0]        rr_ptr;
  logic [1:0]        winner;
  logic              found;
  logic              issue;
  logic              regwrite_q;
  logic [2:0]        bwr_q;
  logic [DATA_W-1:0] wdata_q;

  // Gather incoming requests; ready depends only on registered pend.
  always_comb begin
    valid      = {bus.sp_valid, bus.link_valid, bus.mem_valid, bus.alu_valid};
    accept     = valid & ~pend;
    in_data[0] = bus.alu_data;
    in_data[1] = bus.mem_data;
    in_data[2] = bus.link_data;
    in_data[3] = bus.sp_data;
    in_code[0] = bus.alu_dst ? 3'd1 : 3'd0;
    in_code[1] = bus.mem_dst ? 3'd2 : 3'd0;
    in_code[2] = LINK_CODE;
    in_code[3] = SP_CODE;
  end

  // Pick the first pending requester starting at rr_ptr.
  always_comb begin
    logic [1:0] idx;
    idx    = '0;
    winner = rr_ptr;
    found  = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && pend[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    issue = found & ~bus.hold;
  end

  // Capture accepted requests and issue at most one write per cycle.
  // Accept and issue never touch the same pend bit in one edge, since a
  // pending requester is not ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= '0;
      rr_ptr     <= '0;
      regwrite_q <= 1'b0;
      bwr_q      <= '0;
      wdata_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        code_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (accept[i]) begin
          pend[i]   <= 1'b1;
          data_q[i] <= in_data[i];
          code_q[i] <= in_code[i];
        end
      end
      if (issue) begin
        regwrite_q   <= 1'b1;
        bwr_q        <= code_q[winner];
        wdata_q      <= data_q[winner];
        pend[winner] <= 1'b0;
        rr_ptr       <= winner + 2'd1;
      end else begin
        regwrite_q <= 1'b0;
      end
    end
  end

  assign bus.alu_ready     = ~pend[0];
  assign bus.mem_ready     = ~pend[1];
  assign bus.link_ready    = ~pend[2];
  assign bus.sp_ready      = ~pend[3];
  assign bus.busy          = |pend;
  assign bus.RegWrite      = regwrite_q;
  assign bus.BancoWriteReg = bwr_q;
  assign bus.WriteData     = wdata_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a write scoreboard.
module tb_reg_write_arbiter;

  typedef struct packed {
    logic [2:0]  code;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  reg_write_arbiter_if #(.DATA_W(32)) bus ();

  reg_write_arbiter #(
    .DATA_W   (32),
    .SP_CODE  (3'd3),
    .LINK_CODE(3'd4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [31:0] d);
    exp_t e;
    e.code = c;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && bus.RegWrite === 1'b1) begin
      check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_code", {29'b0, bus.BancoWriteReg}, {29'b0, e.code});
        check("sb_data", bus.WriteData, e.data);
      end
    end
  end

  initial begin
    bus.alu_valid = 0; bus.alu_dst = 0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_dst = 0; bus.mem_data = '0;
    bus.link_valid = 0; bus.link_data = '0;
    bus.sp_valid = 0; bus.sp_data = '0;
    bus.hold = 0;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_regwrite", {31'b0, bus.RegWrite}, 32'd0);
    check("rst_bwr", {29'b0, bus.BancoWriteReg}, 32'd0);
    check("rst_wdata", bus.WriteData, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_ready", {28'b0, bus.sp_ready, bus.link_ready, bus.mem_ready, bus.alu_ready}, 32'hF);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single ALU request
    step();
    bus.alu_valid = 1; bus.alu_dst = 1; bus.alu_data = 32'h1234;
    push(3'd1, 32'h1234);
    step();
    bus.alu_valid = 0;
    check("t1_alu_ready_low", {31'b0, bus.alu_ready}, 32'd0);
    check("t1_busy", {31'b0, bus.busy}, 32'd1);
    check("t1_no_write_yet", {31'b0, bus.RegWrite}, 32'd0);
    step();
    check("t1_regwrite", {31'b0, bus.RegWrite}, 32'd1);
    check("t1_bwr", {29'b0, bus.BancoWriteReg}, 32'd1);
    check("t1_wdata", bus.WriteData, 32'h1234);
    check("t1_alu_ready_back", {31'b0, bus.alu_ready}, 32'd1);
    step();
    check("t1_regwrite_off", {31'b0, bus.RegWrite}, 32'd0);
    check("t1_busy_off", {31'b0, bus.busy}, 32'd0);

    // All four at once after reset
    reset = 1'b1;
    #2 reset = 1'b0;
    bus.alu_valid = 1; bus.alu_dst = 0; bus.alu_data = 32'hAAAA0001;
    bus.mem_valid = 1; bus.mem_dst = 1; bus.mem_data = 32'hBBBB0002;
    bus.link_valid = 1; bus.link_data = 32'hCCCC0003;
    bus.sp_valid = 1; bus.sp_data = 32'hDDDD0004;
    push(3'd0, 32'hAAAA0001);
    push(3'd2, 32'hBBBB0002);
    push(3'd4, 32'hCCCC0003);
    push(3'd3, 32'hDDDD0004);
    step();
    bus.alu_valid = 0; bus.mem_valid = 0; bus.link_valid = 0; bus.sp_valid = 0;
    check("t2_ready_all_low", {28'b0, bus.sp_ready, bus.link_ready, bus.mem_ready, bus.alu_ready}, 32'h0);
    step();
    check("t2_first_code", {29'b0, bus.BancoWriteReg}, 32'd0);
    step();
    check("t2_second_code", {29'b0, bus.BancoWriteReg}, 32'd2);
    step();
    check("t2_third_code", {29'b0, bus.BancoWriteReg}, 32'd4);
    step();
    check("t2_fourth_code", {29'b0, bus.BancoWriteReg}, 32'd3);
    check("t2_busy_after", {31'b0, bus.busy}, 32'd0);
    step();
    check("t2_regwrite_off", {31'b0, bus.RegWrite}, 32'd0);

    // Fairness: alu and sp re-request whenever ready
    for (int k = 0; k < 4; k++) begin
      push(3'd1, 32'h100 + 32'(k));
      push(3'd3, 32'h200 + 32'(k));
    end
    begin
      int ak;
      int sk;
      ak = 0;
      sk = 0;
      bus.alu_dst = 1;
      for (int c = 0; c < 12; c++) begin
        bus.alu_valid = (bus.alu_ready && ak < 4);
        if (bus.alu_valid) begin
          bus.alu_data = 32'h100 + 32'(ak);
          ak++;
        end
        bus.sp_valid = (bus.sp_ready && sk < 4);
        if (bus.sp_valid) begin
          bus.sp_data = 32'h200 + 32'(sk);
          sk++;
        end
        step();
      end
      bus.alu_valid = 0;
      bus.sp_valid = 0;
    end
    check("t3_drained", 32'(sb.size()), 32'd0);

    // Hold with link and sp pending
    bus.hold = 1;
    bus.link_valid = 1; bus.link_data = 32'hCAFE0001;
    bus.sp_valid = 1; bus.sp_data = 32'h7FFFFFF0;
    push(3'd4, 32'hCAFE0001);
    push(3'd3, 32'h7FFFFFF0);
    step();
    bus.link_valid = 0; bus.sp_valid = 0;
    for (int h = 0; h < 3; h++) begin
      check("t4_hold_regwrite", {31'b0, bus.RegWrite}, 32'd0);
      check("t4_hold_busy", {31'b0, bus.busy}, 32'd1);
      if (h < 2) step();
    end
    bus.hold = 0;
    step();
    check("t4_link_first", {29'b0, bus.BancoWriteReg}, 32'd4);
    step();
    check("t4_sp_second", {29'b0, bus.BancoWriteReg}, 32'd3);
    step();
    check("t4_busy_off", {31'b0, bus.busy}, 32'd0);

    // Backpressure on mem
    bus.mem_valid = 1; bus.mem_dst = 0; bus.mem_data = 32'h11110001;
    push(3'd0, 32'h11110001);
    push(3'd0, 32'h22220002);
    step();
    check("t5_mem_ready_low", {31'b0, bus.mem_ready}, 32'd0);
    bus.mem_data = 32'h22220002;
    step();
    check("t5_first_data", bus.WriteData, 32'h11110001);
    check("t5_mem_ready_back", {31'b0, bus.mem_ready}, 32'd1);
    step();
    bus.mem_valid = 0;
    check("t5_second_accepted", {31'b0, bus.mem_ready}, 32'd0);
    check("t5_gap", {31'b0, bus.RegWrite}, 32'd0);
    step();
    check("t5_second_data", bus.WriteData, 32'h22220002);
    step();

    // Reset mid-cycle with three entries pending (rr_ptr now 2, so link goes first)
    bus.alu_valid = 1; bus.alu_dst = 0; bus.alu_data = 32'hE0;
    bus.mem_valid = 1; bus.mem_dst = 1; bus.mem_data = 32'hE1;
    bus.link_valid = 1; bus.link_data = 32'hE2;
    bus.sp_valid = 1; bus.sp_data = 32'hE3;
    push(3'd4, 32'hE2);
    step();
    bus.alu_valid = 0; bus.mem_valid = 0; bus.link_valid = 0; bus.sp_valid = 0;
    step();
    check("t6_issuing", {31'b0, bus.RegWrite}, 32'd1);
    #6 reset = 1'b1;
    #1;
    check("t6_rst_regwrite", {31'b0, bus.RegWrite}, 32'd0);
    check("t6_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("t6_rst_bwr", {29'b0, bus.BancoWriteReg}, 32'd0);
    check("t6_rst_wdata", bus.WriteData, 32'd0);
    check("t6_rst_ready", {28'b0, bus.sp_ready, bus.link_ready, bus.mem_ready, bus.alu_ready}, 32'hF);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) step();
    check("t6_no_write", {31'b0, bus.RegWrite}, 32'd0);
    check("t6_idle", {31'b0, bus.busy}, 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Arbitrates the single register-bank write port of the multicycle datapath between four requesters:
  - ALU result
  - memory load
  - JAL link
  - stack-pointer update
- Each requester has a one-entry holding buffer. A round-robin scheduler issues at most one write per cycle.
- It drives the 3-bit destination-select code consumed by the write-register mux, plus RegWrite and the write data.
- It sits between the control unit and the register bank.

Parameters:
- DATA_W, 32, width of write data.
- SP_CODE, 3, select code for $29 (stack pointer).
- LINK_CODE, 4, select code for $31 (JAL link).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU write request.
- alu_dst  in  1  ALU destination: 0 = rt, 1 = rd.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request can be accepted.
- mem_valid  in  1  load write request.
- mem_dst  in  1  load destination: 0 = rt, 1 = rs (base writeback).
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request can be accepted.
- link_valid  in  1  JAL link write request.
- link_data  in  DATA_W  return address.
- link_ready  out  1  link request can be accepted.
- sp_valid  in  1  SP update request.
- sp_data  in  DATA_W  new SP value.
- sp_ready  out  1  SP request can be accepted.
- hold  in  1  control unit freezes register writes.
- BancoWriteReg  out  3  select code to the write-register mux.
- RegWrite  out  1  register bank write enable, one-cycle pulse.
- WriteData  out  DATA_W  data to the register bank.
- busy  out  1  any request pending.

Behaviour:
- Requester index order: 0 = alu, 1 = mem, 2 = link, 3 = sp.
- Per requester i, state is pend[i] plus a captured data/code entry.
- ready_i = !pend[i]. This is registered-state only, with no combinational path from valid.
- Accept: when valid_i && ready_i at an edge:
  - pend[i] <= 1.
  - The data is captured.
  - The code is captured:
    - alu: alu_dst ? 1 : 0.
    - mem: mem_dst ? 2 : 0.
    - link: LINK_CODE.
    - sp: SP_CODE.
- Issue: at each edge, if !hold and |pend:
  - Winner = first pending index scanning rr_ptr, rr_ptr+1, ... (mod 4).
  - RegWrite <= 1.
  - BancoWriteReg <= code[winner].
  - WriteData <= data[winner].
  - pend[winner] <= 0.
  - rr_ptr <= (winner+1) mod 4.
- Otherwise RegWrite <= 0. BancoWriteReg and WriteData hold their last values. rr_ptr is unchanged.
- Latency: a request accepted at edge N is issued at the earliest at edge N+1, with RegWrite high during cycle N+1..N+2. With no contention, each requester sustains one write every 2 cycles.
- Simultaneous accept and issue on different requesters in the same edge: both take effect.
- A requester cannot be accepted and issued in the same edge, because ready is low while pending.
- hold high: no issue and RegWrite <= 0. Accepts continue, and pend entries are retained. Issue resumes on the first edge with hold low.
- busy = |pend (combinational from registers).
- Reset (async, any time, including mid-issue):
  - pend = 0, rr_ptr = 0.
  - RegWrite = 0, BancoWriteReg = 0, WriteData = 0.
  - All ready = 1, busy = 0.
  - Pending requests are discarded.
- Code values 5–7 are never produced.

Test Plan:
- Single ALU request (alu_dst = 1, data 0x1234) with the arbiter idle:
  - alu_ready drops for one cycle.
  - One edge later: RegWrite = 1, BancoWriteReg = 1, WriteData = 0x1234 for exactly one cycle.
- All four valid in the same cycle after reset (rr_ptr = 0), data A/B/C/D, mem_dst = 1:
  - Issues on four consecutive cycles with codes 0 (alu_dst = 0), 2, 4, 3 and data A, B, C, D.
  - busy is low after the last issue.
- Fairness, with alu and sp re-requesting as soon as ready:
  - Issue order alternates alu, sp, alu, sp. Neither requester is issued twice in a row while the other is pending.
- hold high for 3 cycles while link and sp are pending:
  - RegWrite stays 0 and busy stays 1.
  - After hold falls: link (code 4) issues, then sp (code 3).
- Backpressure: a second mem_valid while mem is pending:
  - mem_ready = 0 and the request is not captured.
  - After issue, the re-presented request is accepted and issued with the new data.
- Reset asserted mid-cycle with 3 entries pending:
  - Immediately RegWrite = 0 and busy = 0.
  - After reset falls, no write occurs without a new request.
